// File: rtl/elastic_port.sv
// Elastic pipeline port: DEPTH-entry circular buffer with valid/ready on both sides.
// Every output is a flop, so no combinational path runs from ready_in to ready_out.
module elastic_port #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push;
  logic             pop;

  assign push = valid_in & ready_q;
  assign pop  = valid_q & ready_in;

  // Next pointers/occupancy, then the head entry as it will look after this edge.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = '0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
    valid_d = (count_d != '0);
    ready_d = (count_d != FULL);
    // A push landing in the slot that becomes the head is not yet in mem_q.
    if (valid_d) begin
      if (push && !flush && (wr_ptr_q == rd_ptr_d)) data_d = data_in;
      else                                          data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
    end
  end

  // Storage is left unreset; data_out is masked to zero whenever it is not valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign count     = count_q;

endmodule
